// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface mem_access_unit_if;
  logic        Bus_Req;
  logic        Bus_We;
  logic [31:0] Bus_Addr;
  logic [3:0]  Bus_Be;
  logic [31:0] Bus_Wdata;
  logic        Bus_Ack;
  logic [31:0] Bus_Rdata;

  modport master (
    output Bus_Req, Bus_We, Bus_Addr, Bus_Be, Bus_Wdata,
    input  Bus_Ack, Bus_Rdata
  );

  modport slave (
    input  Bus_Req, Bus_We, Bus_Addr, Bus_Be, Bus_Wdata,
    output Bus_Ack, Bus_Rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: turns EX/MEM fields into one byte-lane bus
// access with wait states and timeout, returns extended load data to MEM/WB.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic               Clk,
  input  logic               Clr,
  input  logic [31:0]        M_Alu,
  input  logic [31:0]        M_Wdata,
  input  logic [4:0]         M_Rd,
  input  logic               M_Wreg,
  input  logic               M_Reg2reg,
  input  logic               M_Rmem,
  input  logic               M_Wmem,
  input  logic               M_Sign,
  input  logic [1:0]         M_Size,
  mem_access_unit_if.master  bus,
  output logic [31:0]        Mem_D,
  output logic [31:0]        Mem_C,
  output logic [4:0]         Mem_Rd,
  output logic               Mem_Wreg,
  output logic               Mem_Reg2reg,
  output logic               Stall,
  output logic               Exc_Misalign,
  output logic               Exc_Bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;
  logic          abort;

  logic          mem_op;
  logic          misalign;
  logic          start;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext;

  assign mem_op = M_Rmem | M_Wmem;
  // Size 11 is handled like a word everywhere.
  assign misalign = (M_Size == 2'b01) ? M_Alu[0] :
                    (M_Size == 2'b00) ? 1'b0 : (M_Alu[1:0] != 2'b00);
  assign start = (state == IDLE) && mem_op && !misalign;

  // Byte enables and lane-replicated store data for the access about to start.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = M_Wdata;
    case (M_Size)
      2'b00: begin
        be_nxt    = 4'b0001 << M_Alu[1:0];
        wdata_nxt = {4{M_Wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = M_Alu[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{M_Wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half out of the captured word and extend it.
  always_comb begin
    byte_sel = rdata_q[{M_Alu[1:0], 3'b000} +: 8];
    half_sel = M_Alu[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (M_Size)
      2'b00:   load_ext = {{24{M_Sign & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{M_Sign & half_sel[15]}}, half_sel};
      default: load_ext = rdata_q;
    endcase
  end

  // Access FSM: latch the bus request in IDLE, wait for ack or timeout in REQ,
  // present the result for one cycle in DONE. EX/MEM is frozen by Stall, so the
  // M_* fields stay valid through DONE.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      be_q    <= 4'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      rdata_q <= 32'b0;
      cnt     <= '0;
      abort   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q    <= M_Wmem;
          be_q    <= be_nxt;
          addr_q  <= {M_Alu[31:2], 2'b00};
          wdata_q <= wdata_nxt;
          rdata_q <= 32'b0;
          cnt     <= '0;
          abort   <= 1'b0;
          state   <= REQ;
        end
        REQ: begin
          // An ack in the final allowed cycle still completes normally.
          if (bus.Bus_Ack) begin
            rdata_q <= bus.Bus_Rdata;
            state   <= DONE;
          end else if (cnt == CNT_MAX) begin
            abort <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Bus_Req   = (state == REQ);
  assign bus.Bus_We    = we_q;
  assign bus.Bus_Addr  = addr_q;
  assign bus.Bus_Be    = be_q;
  assign bus.Bus_Wdata = wdata_q;

  assign Stall        = start || (state == REQ);
  assign Exc_Misalign = (state == IDLE) && mem_op && misalign;
  assign Exc_Bus      = (state == DONE) && abort;
  assign Mem_D        = (state == DONE) ? load_ext : 32'b0;
  assign Mem_C        = M_Alu;
  assign Mem_Rd       = M_Rd;
  assign Mem_Reg2reg  = M_Reg2reg;
  // A combined read+write performs only the store and never writes back.
  assign Mem_Wreg     = M_Wreg && !(M_Rmem && M_Wmem) && !Exc_Misalign && !Exc_Bus;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model, per-cycle compare.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [31:0] M_Alu, M_Wdata;
  logic [4:0]  M_Rd;
  logic        M_Wreg, M_Reg2reg, M_Rmem, M_Wmem, M_Sign;
  logic [1:0]  M_Size;
  logic [31:0] Mem_D, Mem_C;
  logic [4:0]  Mem_Rd;
  logic        Mem_Wreg, Mem_Reg2reg, Stall, Exc_Misalign, Exc_Bus;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Clr(Clr),
    .M_Alu(M_Alu), .M_Wdata(M_Wdata), .M_Rd(M_Rd),
    .M_Wreg(M_Wreg), .M_Reg2reg(M_Reg2reg), .M_Rmem(M_Rmem), .M_Wmem(M_Wmem),
    .M_Sign(M_Sign), .M_Size(M_Size),
    .bus(bus),
    .Mem_D(Mem_D), .Mem_C(Mem_C), .Mem_Rd(Mem_Rd), .Mem_Wreg(Mem_Wreg),
    .Mem_Reg2reg(Mem_Reg2reg), .Stall(Stall),
    .Exc_Misalign(Exc_Misalign), .Exc_Bus(Exc_Bus)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (lane arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return (int'(a[1:0]) / nb) * nb;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    nb = nbytes(sz);
    return 4'(((1 << nb) - 1) << lane_off(sz, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = nbytes(sz);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [31:0] a,
                                             input logic sg, input logic [31:0] data);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(sz);
    v = data >> (8 * lane_off(sz, a));
    if (nb == 4) return v;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = v & mask;
    if (sg && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- per-cycle expectations ----------------
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_mis, e_exb, e_wreg, e_memd_chk, e_bus_chk, e_we, e_last;
  logic [31:0] e_memd, e_addr, e_wdata;
  logic [3:0]  e_be;
  int          r_stall_cnt, r_req_cnt, r_mis_cnt;
  logic [31:0] r_memd, r_wdata;
  logic        r_wreg, r_exb, r_we;
  logic [3:0]  r_be;

  // Single compare process: DUT outputs against the model on every checked cycle.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("stall", Stall, e_stall);
      chk("bus_req", bus.Bus_Req, e_req);
      chk("exc_misalign", Exc_Misalign, e_mis);
      chk("exc_bus", Exc_Bus, e_exb);
      chk("mem_wreg", Mem_Wreg, e_wreg);
      chk("mem_c", Mem_C, M_Alu);
      chk("mem_rd", Mem_Rd, M_Rd);
      chk("mem_reg2reg", Mem_Reg2reg, M_Reg2reg);
      if (e_memd_chk) chk("mem_d", Mem_D, e_memd);
      if (e_bus_chk) begin
        chk("bus_addr", bus.Bus_Addr, e_addr);
        chk("bus_be", bus.Bus_Be, e_be);
        chk("bus_wdata", bus.Bus_Wdata, e_wdata);
        chk("bus_we", bus.Bus_We, e_we);
      end
      r_stall_cnt += Stall;
      r_req_cnt   += bus.Bus_Req;
      r_mis_cnt   += Exc_Misalign;
      if (bus.Bus_Req) begin
        r_be = bus.Bus_Be; r_wdata = bus.Bus_Wdata; r_we = bus.Bus_We;
      end
      if (e_last) begin
        r_memd = Mem_D; r_wreg = Mem_Wreg; r_exb = Exc_Bus;
      end
    end
  end

  // One instruction through MEM. w = wait states before ack; w >= TO means no ack.
  task automatic run_op(input logic rm, input logic wm, input logic wr, input logic sg,
                        input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdv, input int w);
    logic op, mis, both, ack_ok, in_req, done;
    logic [31:0] cap;
    int nreq, total;
    M_Rmem = rm; M_Wmem = wm; M_Wreg = wr; M_Sign = sg; M_Size = sz;
    M_Alu = a; M_Wdata = d; M_Rd = 5'($urandom); M_Reg2reg = 1'($urandom % 2);
    op     = rm | wm;
    mis    = op && ((int'(a[1:0]) % nbytes(sz)) != 0);
    both   = rm & wm;
    ack_ok = (w < TO);
    nreq   = ack_ok ? w + 1 : TO;
    total  = (op && !mis) ? nreq + 2 : 1;
    cap    = 32'h0;
    r_stall_cnt = 0; r_req_cnt = 0; r_mis_cnt = 0;
    r_be = '0; r_wdata = '0; r_we = 1'b0;
    for (int k = 0; k < total; k++) begin
      in_req     = op && !mis && (k >= 1) && (k <= nreq);
      done       = op && !mis && (k == nreq + 1);
      e_stall    = op && !mis && (k <= nreq);
      e_req      = in_req;
      e_mis      = mis;
      e_exb      = done && !ack_ok;
      e_wreg     = wr && !both && !mis && !(done && !ack_ok);
      e_memd     = done ? model_load(sz, a, sg, cap) : 32'h0;
      e_memd_chk = !(done && !ack_ok);
      e_bus_chk  = in_req;
      e_addr     = a & ~32'h3;
      e_be       = model_be(sz, a);
      e_wdata    = model_wdata(sz, d);
      e_we       = wm;
      e_last     = (k == total - 1);
      if (in_req && ack_ok && (k == w + 1)) begin
        bus.Bus_Ack = 1'b1; bus.Bus_Rdata = rdv; cap = rdv;
      end else begin
        // Stray acks outside REQ must be ignored.
        bus.Bus_Ack = in_req ? 1'b0 : 1'($urandom % 2);
        bus.Bus_Rdata = $urandom;
      end
      chk_en = 1'b1;
      @(posedge Clk); #1;
    end
    chk_en = 1'b0;
    bus.Bus_Ack = 1'b0;
  endtask

  initial begin
    Clr = 1'b1;
    M_Alu = 32'h55; M_Wdata = 32'h0; M_Rd = 5'd3;
    M_Wreg = 1'b1; M_Reg2reg = 1'b0; M_Rmem = 1'b0; M_Wmem = 1'b0; M_Sign = 1'b0; M_Size = 2'b10;
    bus.Bus_Ack = 1'b0; bus.Bus_Rdata = 32'h0;
    #12;
    chk("rst_bus_req", bus.Bus_Req, 1'b0);
    chk("rst_bus_we", bus.Bus_We, 1'b0);
    chk("rst_bus_addr", bus.Bus_Addr, 32'h0);
    chk("rst_bus_be", bus.Bus_Be, 4'h0);
    chk("rst_bus_wdata", bus.Bus_Wdata, 32'h0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_mem_d", Mem_D, 32'h0);
    chk("rst_exc_bus", Exc_Bus, 1'b0);
    chk("rst_mem_c", Mem_C, 32'h55);
    @(posedge Clk); #1 Clr = 1'b0;

    // Word load, ack on first REQ cycle.
    run_op(1, 0, 1, 0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("wl_stall_cycles", r_stall_cnt, 2);
    chk("wl_be", r_be, 4'b1111);
    chk("wl_mem_d", r_memd, 32'hDEADBEEF);
    chk("wl_wreg", r_wreg, 1'b1);

    // Signed / unsigned byte load from lane 3.
    run_op(1, 0, 1, 1, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 0);
    chk("lb_signed", r_memd, 32'hFFFFFF80);
    run_op(1, 0, 1, 0, 2'b00, 32'h103, 32'h0, 32'h80FFFFFF, 1);
    chk("lb_unsigned", r_memd, 32'h00000080);

    // Half store, three wait states (ack on the last allowed REQ cycle).
    run_op(0, 1, 0, 0, 2'b01, 32'h202, 32'h1234ABCD, 32'h0, 3);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_we", r_we, 1'b1);
    chk("sh_stall_cycles", r_stall_cnt, 5);
    chk("sh_req_cycles", r_req_cnt, 4);
    chk("sh_no_abort", r_exb, 1'b0);

    // Misaligned word load.
    run_op(1, 0, 1, 0, 2'b10, 32'h101, 32'h0, 32'h0, 0);
    chk("mis_flag_cycles", r_mis_cnt, 1);
    chk("mis_stall", r_stall_cnt, 0);
    chk("mis_req", r_req_cnt, 0);
    chk("mis_wreg", r_wreg, 1'b0);

    // Timeout with no ack.
    run_op(1, 0, 1, 0, 2'b10, 32'h400, 32'h0, 32'h0, 10);
    chk("to_req_cycles", r_req_cnt, TO);
    chk("to_exc_bus", r_exb, 1'b1);
    chk("to_wreg", r_wreg, 1'b0);

    // Clr during REQ abandons the access immediately.
    M_Rmem = 1'b1; M_Wmem = 1'b0; M_Size = 2'b10; M_Alu = 32'h300; bus.Bus_Ack = 1'b0;
    @(posedge Clk); #1;
    chk("clr_pre_req", bus.Bus_Req, 1'b1);
    #2 Clr = 1'b1;
    #1;
    chk("clr_req_drop", bus.Bus_Req, 1'b0);
    chk("clr_addr", bus.Bus_Addr, 32'h0);
    @(posedge Clk); #1 Clr = 1'b0;
    run_op(0, 0, 1, 0, 2'b10, 32'h12345678, 32'h0, 32'h0, 0);
    chk("clr_alu_stall", r_stall_cnt, 0);
    chk("clr_alu_wreg", r_wreg, 1'b1);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = int'($urandom % 8);
      run_op(kind == 1 || kind == 2 || kind == 5,
             kind == 3 || kind == 4 || kind == 5,
             1'($urandom % 2), 1'($urandom % 2), 2'($urandom % 4),
             $urandom, $urandom, $urandom, int'($urandom % 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store controller of the 5-stage pipelined CPU. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM control and data fields into byte-lane data-memory bus transactions, with wait-state handshake and timeout. It returns aligned, extended load data plus the pass-through ALU result and destination fields. Its Stall output drives the MEM/WB write enable low and freezes the earlier stages.

## Interface
- TIMEOUT, 16: maximum REQ cycles without Bus_Ack before the access is aborted (≥2).
- Clk  in  1  rising-edge clock; the only clock.
- Clr  in  1  asynchronous, active-high reset.
- M_Alu  in  32  ALU result / effective address from EX/MEM.
- M_Wdata  in  32  store data (rt).
- M_Rd  in  5  destination register.
- M_Wreg, M_Reg2reg, M_Rmem, M_Wmem, M_Sign  in  1 each  register write, load-select, memory read, memory write, signed load.
- M_Size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- Bus_Ack  in  1  memory completes the current request this cycle.
- Bus_Rdata  in  32  read data, valid with Bus_Ack.
- Bus_Req, Bus_We  out  1  request and write strobe.
- Bus_Addr  out  32  word address {M_Alu[31:2],2'b00}.
- Bus_Be  out  4  byte enables, little-endian.
- Bus_Wdata  out  32  lane-replicated store data.
- Mem_D  out  32  load data to MEM/WB D_in.
- Mem_C  out  32  M_Alu passed through to C_in.
- Mem_Rd  out  5  M_Rd passed through.
- Mem_Wreg, Mem_Reg2reg  out  1  write-back controls to MEM/WB.
- Stall  out  1  1 = hold EX/MEM and earlier stages, MEM/WB We low.
- Exc_Misalign, Exc_Bus  out  1  exception flags.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- IDLE, no memory op: Stall=0, Mem_D=0, the block is fully combinational pass-through.
- IDLE, M_Rmem|M_Wmem aligned:
  - Stall=1.
  - The bus registers load: Addr, Be, Wdata, We=M_Wmem.
  - Next state is REQ.
- Alignment: half requires Alu[0]=0; word requires Alu[1:0]=0.
- Misaligned op in IDLE:
  - Exc_Misalign=1 for that cycle.
  - No bus access, Stall=0.
  - Mem_Wreg forced 0; the instruction retires as a no-op.
- REQ: Bus_Req=1, Stall=1.
  - On Bus_Ack: capture Bus_Rdata and go to DONE.
  - Otherwise increment the timeout counter (cleared on entry).
  - If the counter reaches TIMEOUT-1 with no ack: set the abort flag and go to DONE.
  - An ack in that same cycle wins, with no abort.
- DONE: Bus_Req=0, Stall=0.
  - Mem_D = extracted captured data.
  - Exc_Bus = abort flag.
  - If aborted, Mem_Wreg forced 0.
  - Next state is always IDLE; the same instruction is never re-issued.
- Store lanes:
  - Byte: Wdata={4{d[7:0]}}, Be=0001<<Alu[1:0].
  - Half: Wdata={2{d[15:0]}}, Be=Alu[1]?1100:0011.
  - Word: Be=1111.
- Load extract: select byte Alu[1:0] or half Alu[1], then sign-extend if M_Sign, otherwise zero-extend.
- Rmem&Wmem both set: perform the store and force Mem_Wreg=0.
- Mem_Reg2reg, Mem_C and Mem_Rd are always combinational copies of their inputs.
- Mem_Wreg = M_Wreg unless forced 0 per the rules above.
- Bus_Ack outside REQ is ignored.

## Timing
- Reset (async, immediate): state IDLE; Bus_Req, Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, captured data, counter and abort flag all 0.
- After reset, Exc_Bus=0 and Mem_D=0; pass-through outputs follow their inputs.
- Clr asserted mid-REQ drops Bus_Req at once and abandons the access.
- Memory op with ack in the first REQ cycle:
  - Cycle 0 IDLE (Stall=1).
  - Cycle 1 REQ (Stall=1).
  - Cycle 2 DONE (Stall=0); MEM/WB captures at the end of cycle 2.
  - Minimum 2 stall cycles.
- Each extra wait state adds one stall cycle.
- Timeout case: TIMEOUT REQ cycles, then DONE.
- Back-to-back memory ops: DONE → IDLE → REQ; the second op starts its IDLE cycle right after DONE.

## Test plan
- Word load: Alu=0x100, ack on 1st REQ cycle, Rdata=0xDEADBEEF.
  - Stall high 2 cycles, Bus_Be=1111.
  - In DONE: Mem_D=0xDEADBEEF, Mem_Wreg=1.
- Signed byte load: Alu=0x103, Rdata=0x80FFFFFF → Mem_D=0xFFFFFF80. Unsigned → 0x00000080.
- Half store: Alu=0x202, Wdata=0x1234ABCD → Bus_Be=1100, Bus_Wdata=0xABCDABCD, Bus_We=1. Three wait states → Stall high 5 cycles.
- Misaligned word load at 0x101:
  - Exc_Misalign=1 for one cycle, Stall=0.
  - Bus_Req never rises, Mem_Wreg=0.
- Timeout, TIMEOUT=4, no ack:
  - Bus_Req high exactly 4 cycles.
  - DONE: Exc_Bus=1, Mem_Wreg=0.
  - Ack on the 4th cycle instead → normal completion.
- Clr pulsed during REQ: Bus_Req→0 asynchronously, state IDLE. After release, an ALU op passes through with Stall=0.
